// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_pkg
//  Description : Shared types and geometry constants for the direct-mapped
//                write-back data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_pkg;

   // Miss-handling controller states
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_FILL      = 2'd2
   } state_e;

   localparam int ADDR_W       = 32;
   localparam int WORD_W       = 32;
   localparam int DEF_SET_LOG  = 3;
   localparam int DEF_WORD_LOG = 2;

   // Derived field widths for the default geometry
   localparam int DEF_WORD_IDX_W = DEF_WORD_LOG;
   localparam int DEF_INDEX_W    = DEF_SET_LOG;
   localparam int DEF_TAG_W      = ADDR_W - DEF_SET_LOG - DEF_WORD_LOG - 2;

   // Tag width for an arbitrary geometry (two byte-offset bits are dropped)
   function automatic int tag_width(input int set_log, input int word_log);
      return ADDR_W - set_log - word_log - 2;
   endfunction

   // Line width in bits for an arbitrary geometry
   function automatic int line_width(input int word_log);
      return WORD_W << word_log;
   endfunction

endpackage : dcache_pkg
`default_nettype wire

// File: rtl/dcache_line_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_line_array
//  Description : Data, tag, valid and dirty storage for the direct-mapped
//                cache. One combinational read port, one write port that
//                either installs a whole line or updates a single word.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_line_array
   import dcache_pkg::*;
#(
   parameter int SET_LOG  = DEF_SET_LOG,
   parameter int WORD_LOG = DEF_WORD_LOG
) (
   input  logic                                    clk_i,
   input  logic                                    rst_i,
   // read port
   input  logic [SET_LOG-1:0]                      rd_index_i,
   output logic [line_width(WORD_LOG)-1:0]         rd_line_o,
   output logic [tag_width(SET_LOG, WORD_LOG)-1:0] rd_tag_o,
   output logic                                    rd_valid_o,
   output logic                                    rd_dirty_o,
   // write port
   input  logic [SET_LOG-1:0]                      wr_index_i,
   input  logic                                    line_we_i,
   input  logic [line_width(WORD_LOG)-1:0]         line_i,
   input  logic [tag_width(SET_LOG, WORD_LOG)-1:0] tag_i,
   input  logic                                    word_we_i,
   input  logic [WORD_LOG-1:0]                     word_sel_i,
   input  logic [WORD_W-1:0]                       word_i
);

   localparam int SETS   = 1 << SET_LOG;
   localparam int WPL    = 1 << WORD_LOG;
   localparam int LINE_W = line_width(WORD_LOG);
   localparam int TAG_W  = tag_width(SET_LOG, WORD_LOG);

   logic [LINE_W-1:0] data_q [SETS];
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [SETS-1:0]   valid_q;
   logic [SETS-1:0]   dirty_q;
   logic [LINE_W-1:0] w_merged;

   assign rd_line_o  = data_q[rd_index_i];
   assign rd_tag_o   = tag_q[rd_index_i];
   assign rd_valid_o = valid_q[rd_index_i];
   assign rd_dirty_o = dirty_q[rd_index_i];

   // Target line with the selected word replaced by the store data
   always_comb begin
      w_merged = data_q[wr_index_i];
      for (int w = 0; w < WPL; w++) begin
         if (word_sel_i == WORD_LOG'(w)) begin
            w_merged[w*WORD_W +: WORD_W] = word_i;
         end
      end
   end

   // Data and tag storage; contents survive reset, only the valid bits matter
   always_ff @(posedge clk_i) begin
      if (line_we_i) begin
         data_q[wr_index_i] <= line_i;
         tag_q[wr_index_i]  <= tag_i;
      end else if (word_we_i) begin
         data_q[wr_index_i] <= w_merged;
      end
   end

   // Valid/dirty bits: fill installs a clean line, a word store dirties it
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we_i) begin
         valid_q[wr_index_i] <= 1'b1;
         dirty_q[wr_index_i] <= 1'b0;
      end else if (word_we_i) begin
         dirty_q[wr_index_i] <= 1'b1;
      end
   end

endmodule : dcache_line_array
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
//  Module      : data_cache
//  Description : Direct-mapped, write-back, write-allocate data cache for the
//                MEM stage. Hits are serviced combinationally; misses stall
//                the pipeline through DCacheMiss while a controller writes
//                back a dirty victim and fills the requested line.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_cache
   import dcache_pkg::*;
#(
   parameter int SET_LOG  = DEF_SET_LOG,
   parameter int WORD_LOG = DEF_WORD_LOG
) (
   input  logic                            CPU_CLK,
   input  logic                            CPU_RST,
   input  logic                            rd_req,
   input  logic                            wr_req,
   input  logic [31:0]                     addr,
   input  logic [31:0]                     wr_data,
   output logic [31:0]                     rd_data,
   output logic                            DCacheMiss,
   output logic                            mem_rd_req,
   output logic                            mem_wr_req,
   output logic [31:0]                     mem_addr,
   output logic [line_width(WORD_LOG)-1:0] mem_wr_line,
   input  logic [line_width(WORD_LOG)-1:0] mem_rd_line,
   input  logic                            mem_gnt
);

   localparam int WPL    = 1 << WORD_LOG;
   localparam int LINE_W = line_width(WORD_LOG);
   localparam int TAG_W  = tag_width(SET_LOG, WORD_LOG);
   localparam int OFF_W  = WORD_LOG + 2;

   state_e               state_q, state_d;
   logic [TAG_W-1:0]     req_tag_q, req_tag_d;
   logic [SET_LOG-1:0]   req_index_q, req_index_d;

   logic [WORD_LOG-1:0]  w_word;
   logic [SET_LOG-1:0]   w_index;
   logic [TAG_W-1:0]     w_tag;
   logic [SET_LOG-1:0]   w_arr_index;
   logic [LINE_W-1:0]    w_rd_line;
   logic [TAG_W-1:0]     w_rd_tag;
   logic                 w_rd_valid;
   logic                 w_rd_dirty;
   logic                 w_hit;
   logic                 w_line_we;
   logic                 w_word_we;
   logic                 w_unused;

   assign w_word  = addr[WORD_LOG+1:2];
   assign w_index = addr[SET_LOG+WORD_LOG+1:WORD_LOG+2];
   assign w_tag   = addr[31:SET_LOG+WORD_LOG+2];
   assign w_unused = ^addr[1:0];

   // While a miss is in flight the array looks at the latched line, so the
   // victim tag/data stay visible for write-back regardless of the CPU bus.
   assign w_arr_index = (state_q == ST_IDLE) ? w_index : req_index_q;

   assign w_hit      = w_rd_valid && (w_rd_tag == w_tag) && (state_q == ST_IDLE);
   assign DCacheMiss = (rd_req || wr_req) && !w_hit;
   assign w_word_we  = wr_req && w_hit;
   assign mem_wr_line = w_rd_line;

   // Word select for loads; pre-write data is shown when load and store coincide
   always_comb begin
      rd_data = '0;
      for (int w = 0; w < WPL; w++) begin
         if (w_word == WORD_LOG'(w)) begin
            rd_data = w_rd_line[w*WORD_W +: WORD_W];
         end
      end
   end

   // Miss controller register; reset abandons any memory transaction
   always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
      if (CPU_RST) begin
         state_q     <= ST_IDLE;
         req_tag_q   <= '0;
         req_index_q <= '0;
      end else begin
         state_q     <= state_d;
         req_tag_q   <= req_tag_d;
         req_index_q <= req_index_d;
      end
   end

   // Miss controller next state and memory-side outputs
   always_comb begin
      state_d     = state_q;
      req_tag_d   = req_tag_q;
      req_index_d = req_index_q;
      mem_rd_req  = 1'b0;
      mem_wr_req  = 1'b0;
      mem_addr    = {req_tag_q, req_index_q, {OFF_W{1'b0}}};
      w_line_we   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (DCacheMiss) begin
               req_tag_d   = w_tag;
               req_index_d = w_index;
               state_d     = (w_rd_valid && w_rd_dirty) ? ST_WRITEBACK : ST_FILL;
            end
         end
         ST_WRITEBACK: begin
            mem_wr_req = 1'b1;
            mem_addr   = {w_rd_tag, req_index_q, {OFF_W{1'b0}}};
            if (mem_gnt) begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            mem_rd_req = 1'b1;
            if (mem_gnt) begin
               w_line_we = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   dcache_line_array #(
      .SET_LOG  (SET_LOG),
      .WORD_LOG (WORD_LOG)
   ) u_array (
      .clk_i      (CPU_CLK),
      .rst_i      (CPU_RST),
      .rd_index_i (w_arr_index),
      .rd_line_o  (w_rd_line),
      .rd_tag_o   (w_rd_tag),
      .rd_valid_o (w_rd_valid),
      .rd_dirty_o (w_rd_dirty),
      .wr_index_i (w_line_we ? req_index_q : w_index),
      .line_we_i  (w_line_we),
      .line_i     (mem_rd_line),
      .tag_i      (req_tag_q),
      .word_we_i  (w_word_we),
      .word_sel_i (w_word),
      .word_i     (wr_data)
   );

endmodule : data_cache
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_data_cache
//  Description : Self-checking bench for data_cache with a reference memory
//                model, a load-data scoreboard and a memory-transaction
//                scoreboard checked by the memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache;

   localparam int LAT    = 2;
   localparam int LINE_W = 128;
   localparam int WPL    = 4;
   localparam int BOUND  = 60;

   typedef struct {
      bit               is_wr;
      logic [31:0]      a;
      logic [LINE_W-1:0] line;
   } mem_txn_t;

   logic              CPU_CLK = 1'b0;
   logic              CPU_RST;
   logic              rd_req, wr_req;
   logic [31:0]       addr, wr_data;
   logic [31:0]       rd_data;
   logic              DCacheMiss, mem_rd_req, mem_wr_req;
   logic [31:0]       mem_addr;
   logic [LINE_W-1:0] mem_wr_line, mem_rd_line;
   logic              mem_gnt;

   int checks = 0;
   int errors = 0;
   bit mem_en = 1'b1;
   bit inject_gnt = 1'b0;

   logic [31:0] back_mem [logic [31:0]];
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] exp_data_q [$];
   mem_txn_t    exp_mem_q  [$];

   always #5 CPU_CLK = ~CPU_CLK;

   data_cache dut (
      .CPU_CLK     (CPU_CLK),
      .CPU_RST     (CPU_RST),
      .rd_req      (rd_req),
      .wr_req      (wr_req),
      .addr        (addr),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .DCacheMiss  (DCacheMiss),
      .mem_rd_req  (mem_rd_req),
      .mem_wr_req  (mem_wr_req),
      .mem_addr    (mem_addr),
      .mem_wr_line (mem_wr_line),
      .mem_rd_line (mem_rd_line),
      .mem_gnt     (mem_gnt)
   );

   function automatic logic [31:0] back_rd(input logic [31:0] a);
      if (back_mem.exists(a)) return back_mem[a];
      return 32'h5A00_0000 | a;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return 32'h5A00_0000 | a;
   endfunction

   function automatic logic [LINE_W-1:0] ref_line(input logic [31:0] base);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < WPL; i++) l[i*32 +: 32] = ref_rd(base + 32'(4*i));
      return l;
   endfunction

   function automatic logic [LINE_W-1:0] back_line(input logic [31:0] base);
      logic [LINE_W-1:0] l;
      for (int i = 0; i < WPL; i++) l[i*32 +: 32] = back_rd(base + 32'(4*i));
      return l;
   endfunction

   function automatic mem_txn_t txn(input bit w, input logic [31:0] a, input logic [LINE_W-1:0] l);
      mem_txn_t t;
      t.is_wr = w; t.a = a; t.line = l;
      return t;
   endfunction

   // Memory responder: grants each request after LAT cycles and checks it
   // against the expected-transaction scoreboard.
   initial begin
      int wait_cnt;
      mem_txn_t t;
      wait_cnt = 0;
      mem_gnt = 1'b0;
      mem_rd_line = '0;
      forever begin
         @(negedge CPU_CLK);
         mem_gnt = 1'b0;
         checks++;
         if (mem_rd_req && mem_wr_req) begin
            errors++;
            $display("FAIL mem_excl rd=%0b wr=%0b want not both", mem_rd_req, mem_wr_req);
         end
         if (inject_gnt) begin
            mem_gnt = 1'b1;
            inject_gnt = 1'b0;
         end else if (mem_en && !CPU_RST && (mem_rd_req || mem_wr_req)) begin
            if (wait_cnt == LAT-1) begin
               wait_cnt = 0;
               mem_gnt = 1'b1;
               checks++;
               if (exp_mem_q.size() == 0) begin
                  errors++;
                  $display("FAIL mem_unexpected wr=%0b addr=%h want no request", mem_wr_req, mem_addr);
               end else begin
                  t = exp_mem_q.pop_front();
                  if (mem_wr_req !== t.is_wr || mem_addr !== t.a) begin
                     errors++;
                     $display("FAIL mem_txn got wr=%0b addr=%h want wr=%0b addr=%h",
                              mem_wr_req, mem_addr, t.is_wr, t.a);
                  end
                  if (t.is_wr) begin
                     checks++;
                     if (mem_wr_line !== t.line) begin
                        errors++;
                        $display("FAIL wb_line got %h want %h", mem_wr_line, t.line);
                     end
                  end
               end
               if (mem_wr_req) begin
                  for (int i = 0; i < WPL; i++)
                     back_mem[mem_addr + 32'(4*i)] = mem_wr_line[i*32 +: 32];
               end else begin
                  mem_rd_line = back_line(mem_addr);
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Load: expected word is queued at issue and compared when the hit arrives
   task automatic do_load(input logic [31:0] a, input int exp_miss, input string nm);
      int miss;
      logic [31:0] exp;
      exp_data_q.push_back(ref_rd(a));
      rd_req = 1'b1; wr_req = 1'b0; addr = a;
      miss = 0;
      @(negedge CPU_CLK);
      while (DCacheMiss && miss < BOUND) begin
         miss++;
         @(negedge CPU_CLK);
      end
      exp = exp_data_q.pop_front();
      checks++;
      if (miss >= BOUND) begin
         errors++;
         $display("FAIL %s timeout miss_cycles=%0d want <%0d", nm, miss, BOUND);
      end else if (rd_data !== exp) begin
         errors++;
         $display("FAIL %s rd_data got %h want %h", nm, rd_data, exp);
      end
      checks++;
      if (miss != exp_miss) begin
         errors++;
         $display("FAIL %s_latency got %0d want %0d", nm, miss, exp_miss);
      end
      @(posedge CPU_CLK); #1;
      rd_req = 1'b0;
   endtask

   // Store (optionally with a simultaneous load, which must see the old word)
   task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit also_rd,
                           input int exp_miss, input string nm);
      int miss;
      logic [31:0] exp;
      if (also_rd) exp_data_q.push_back(ref_rd(a));
      rd_req = also_rd; wr_req = 1'b1; addr = a; wr_data = d;
      miss = 0;
      @(negedge CPU_CLK);
      while (DCacheMiss && miss < BOUND) begin
         miss++;
         @(negedge CPU_CLK);
      end
      checks++;
      if (miss >= BOUND) begin
         errors++;
         $display("FAIL %s timeout miss_cycles=%0d want <%0d", nm, miss, BOUND);
      end else if (miss != exp_miss) begin
         errors++;
         $display("FAIL %s_latency got %0d want %0d", nm, miss, exp_miss);
      end
      if (also_rd) begin
         exp = exp_data_q.pop_front();
         checks++;
         if (rd_data !== exp) begin
            errors++;
            $display("FAIL %s prewrite rd_data got %h want %h", nm, rd_data, exp);
         end
      end
      ref_mem[a] = d;
      @(posedge CPU_CLK); #1;
      rd_req = 1'b0; wr_req = 1'b0;
   endtask

   task automatic test_reset();
      CPU_RST = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
      repeat (2) @(posedge CPU_CLK);
      @(negedge CPU_CLK);
      checks++;
      if (DCacheMiss !== 1'b0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle miss=%b rd=%b wr=%b want 0 0 0", DCacheMiss, mem_rd_req, mem_wr_req);
      end
      rd_req = 1'b1; addr = 32'h40;
      #1;
      checks++;
      if (DCacheMiss !== 1'b1 || mem_rd_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_req miss=%b rd=%b want 1 0", DCacheMiss, mem_rd_req);
      end
      rd_req = 1'b0;
      @(posedge CPU_CLK); #1;
      CPU_RST = 1'b0;
   endtask

   task automatic test_read_fill();
      exp_mem_q.push_back(txn(1'b0, 32'h40, '0));
      do_load(32'h40, 1 + LAT, "fill_0x40");
      do_load(32'h4C, 0, "hit_0x4C");
   endtask

   task automatic test_write_hit();
      do_store(32'h44, 32'hDEAD_BEEF, 1'b0, 0, "store_0x44");
      do_load(32'h44, 0, "load_0x44");
   endtask

   task automatic test_writeback();
      exp_mem_q.push_back(txn(1'b1, 32'h40, 128'h00000004_00000003_DEADBEEF_00000001));
      exp_mem_q.push_back(txn(1'b0, 32'hC0, '0));
      do_load(32'hC0, 1 + 2*LAT, "wb_load_0xC0");
      exp_mem_q.push_back(txn(1'b0, 32'h40, '0));
      do_load(32'h44, 1 + LAT, "refill_0x44");
   endtask

   task automatic test_flush();
      int n;
      exp_mem_q.push_back(txn(1'b0, 32'h100, '0));
      rd_req = 1'b1; addr = 32'h100;
      @(negedge CPU_CLK);
      checks++;
      if (DCacheMiss !== 1'b1) begin
         errors++;
         $display("FAIL flush_miss got %b want 1", DCacheMiss);
      end
      @(posedge CPU_CLK); #1;
      rd_req = 1'b0;
      n = 0;
      @(negedge CPU_CLK);
      while (mem_rd_req && n < BOUND) begin
         checks++;
         if (DCacheMiss !== 1'b0) begin
            errors++;
            $display("FAIL flush_noreq_miss got %b want 0", DCacheMiss);
         end
         n++;
         @(negedge CPU_CLK);
      end
      checks++;
      if (n >= BOUND || exp_mem_q.size() != 0) begin
         errors++;
         $display("FAIL flush_complete cycles=%0d pending=%0d want fill done", n, exp_mem_q.size());
      end
      @(posedge CPU_CLK); #1;
      do_load(32'h104, 0, "flush_hit_0x104");
      do_load(32'h100, 0, "flush_hit_0x100");
   endtask

   task automatic test_gnt_idle();
      inject_gnt = 1'b1;
      repeat (3) @(posedge CPU_CLK);
      #1;
      do_load(32'h108, 0, "gnt_idle_hit");
   endtask

   task automatic test_rd_wr_both();
      do_store(32'h10C, 32'h1234_5678, 1'b1, 0, "rdwr_0x10C");
      do_load(32'h10C, 0, "rdwr_after");
   endtask

   task automatic test_back_to_back();
      exp_mem_q.push_back(txn(1'b1, 32'h100, ref_line(32'h100)));
      exp_mem_q.push_back(txn(1'b0, 32'h200, '0));
      do_store(32'h200, 32'hA0A0_A0A0, 1'b0, 1 + 2*LAT, "b2b_store_0x200");
      do_load(32'h200, 0, "b2b_load_0x200");
      do_load(32'h204, 0, "b2b_load_0x204");
      exp_mem_q.push_back(txn(1'b1, 32'h200, ref_line(32'h200)));
      exp_mem_q.push_back(txn(1'b0, 32'h100, '0));
      do_load(32'h104, 1 + 2*LAT, "b2b_load_0x104");
      do_load(32'h10C, 0, "b2b_load_0x10C");
      do_load(32'h4C, 0, "b2b_load_0x4C");
   endtask

   task automatic test_reset_mid_wb();
      do_store(32'h48, 32'h0BAD_F00D, 1'b0, 0, "dirty_0x48");
      mem_en = 1'b0;
      rd_req = 1'b1; addr = 32'hC0;
      @(negedge CPU_CLK);
      @(negedge CPU_CLK);
      checks++;
      if (mem_wr_req !== 1'b1 || mem_addr !== 32'h40) begin
         errors++;
         $display("FAIL rst_wb_active wr=%b addr=%h want 1 00000040", mem_wr_req, mem_addr);
      end
      #1 CPU_RST = 1'b1;
      #1;
      checks++;
      if (mem_wr_req !== 1'b0 || mem_rd_req !== 1'b0 || DCacheMiss !== 1'b1) begin
         errors++;
         $display("FAIL rst_wb_abort wr=%b rd=%b miss=%b want 0 0 1", mem_wr_req, mem_rd_req, DCacheMiss);
      end
      rd_req = 1'b0;
      @(posedge CPU_CLK); #1;
      CPU_RST = 1'b0;
      mem_en = 1'b1;
      ref_mem = back_mem;
      exp_mem_q.push_back(txn(1'b0, 32'h40, '0));
      do_load(32'h48, 1 + LAT, "post_rst_0x48");
   endtask

   initial begin
      back_mem[32'h40] = 32'd1; back_mem[32'h44] = 32'd2;
      back_mem[32'h48] = 32'd3; back_mem[32'h4C] = 32'd4;
      ref_mem = back_mem;
      test_reset();
      test_read_fill();
      test_write_hit();
      test_writeback();
      test_flush();
      test_gnt_idle();
      test_rd_wr_both();
      test_back_to_back();
      test_reset_mid_wb();
      repeat (2) @(posedge CPU_CLK);
      checks++;
      if (exp_mem_q.size() != 0) begin
         errors++;
         $display("FAIL mem_pending got %0d want 0", exp_mem_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time=%0t want finish earlier", $time);
      $fatal(1, "watchdog");
   end

endmodule : tb_data_cache
`default_nettype wire

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter SET_LOG, default 3, meaning log2 of line count (direct-mapped).
REQ-002 Parameter WORD_LOG, default 2, meaning log2 of 32-bit words per line.
REQ-003 Port CPU_CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Port CPU_RST  input  1  reset, asynchronous, active-high.
REQ-005 Port rd_req  input  1  MEM-stage load request.
REQ-006 Port wr_req  input  1  MEM-stage store request.
REQ-007 Port addr  input  32  byte address; bits [1:0] ignored.
REQ-008 Port wr_data  input  32  store word.
REQ-009 Port rd_data  output  32  load word, combinational from array on hit.
REQ-010 Port DCacheMiss  output  1  high while a request is present and not yet serviceable; drives the hazard unit's stall input.
REQ-011 Port mem_rd_req  output  1  line-fill request to memory.
REQ-012 Port mem_wr_req  output  1  victim write-back request to memory.
REQ-013 Port mem_addr  output  32  line-aligned memory address.
REQ-014 Port mem_wr_line  output  32*2^WORD_LOG  victim line data.
REQ-015 Port mem_rd_line  input  32*2^WORD_LOG  fill line data, valid with mem_gnt.
REQ-016 Port mem_gnt  input  1  single-cycle completion pulse for the outstanding mem request.

Function
REQ-017 Address split SHALL be word=[WORD_LOG+1:2], index=[SET_LOG+WORD_LOG+1:WORD_LOG+2], tag=remaining upper bits.
REQ-018 Hit SHALL be valid[index] && tag match && state==IDLE.
REQ-019 DCacheMiss SHALL equal (rd_req|wr_req) && !hit, combinationally, same cycle.
REQ-020 Read hit SHALL present rd_data in the same cycle, zero added latency.
REQ-021 Write hit SHALL update the addressed word and set dirty[index] at the next edge.
REQ-022 rd_req and wr_req both high SHALL be treated as a write; rd_data still shows the pre-write word.
REQ-023 FSM states SHALL be IDLE, WRITEBACK, FILL.
REQ-024 IDLE + request miss: victim valid and dirty -> WRITEBACK, else -> FILL.
REQ-025 WRITEBACK SHALL hold mem_wr_req=1, mem_addr={victim tag,index,0}, mem_wr_line=victim line until mem_gnt, then -> FILL.
REQ-026 FILL SHALL hold mem_rd_req=1, mem_addr={request tag,index,0} until mem_gnt, then write line, set valid, clear dirty, load tag, -> IDLE.
REQ-027 After fill, the held request SHALL hit in the following cycle; a write then completes as a write hit; miss-to-hit latency = 1 + memory cycles per transfer.
REQ-028 mem_rd_req and mem_wr_req SHALL never be high simultaneously; both low in IDLE.
REQ-029 Request dropped mid-miss (pipeline flush) SHALL not abort the FSM; transaction completes and line is installed, DCacheMiss low while no request.
REQ-030 Request address change during WRITEBACK/FILL is illegal (CPU stalled by DCacheMiss); FILL uses the address latched on leaving IDLE.
REQ-031 mem_gnt in IDLE SHALL be ignored.

Reset
REQ-032 CPU_RST SHALL immediately clear all valid and dirty bits, force IDLE, drop mem_rd_req/mem_wr_req to 0.
REQ-033 Reset mid WRITEBACK/FILL SHALL abandon the transaction; data array contents need not be cleared.
REQ-034 During reset DCacheMiss SHALL follow REQ-019 with all lines invalid.

Structure
REQ-035 Shared package dcache_pkg SHALL hold the FSM state enum, default SET_LOG/WORD_LOG, and derived tag/index/word width constants.
REQ-036 One sub-module dcache_line_array SHALL hold data, tag, valid, dirty storage with one combinational read port and one line-write/word-write port.

Verification
REQ-037 Reset, load 0x0000_0040 with memory line {1,2,3,4} -> DCacheMiss=1, mem_rd_req=1 mem_addr=0x40; after mem_gnt next cycle rd_data=1, DCacheMiss=0.
REQ-038 Store 0xDEAD_BEEF to 0x44 after REQ-037 -> no miss, next-cycle load 0x44 returns 0xDEADBEEF.
REQ-039 Load 0x0000_00C0 (same index, new tag) after REQ-038 -> mem_wr_req with mem_addr=0x40 line {1,0xDEADBEEF,3,4}, then mem_rd_req mem_addr=0xC0.
REQ-040 Drop rd_req during FILL -> DCacheMiss=0, fill completes, later load same address hits with no mem request.
REQ-041 Assert CPU_RST during WRITEBACK -> mem_wr_req=0 immediately, state IDLE, prior-hit address now misses.
